// File: rtl/midi_msg_tx.sv
// midi_msg_tx: queues 3-byte MIDI channel messages and sends them as back-to-back 8N1 UART bytes.
module midi_msg_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [7:0]                    status,
  input  logic [6:0]                    data1,
  input  logic [6:0]                    data2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BIT_CYCLES);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [21:0] mem [FIFO_DEPTH];
  logic [21:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [23:0] shreg;
  logic [1:0] byte_idx;
  logic [2:0] bit_idx;
  logic [BW-1:0] baud_cnt;
  logic push, pop, bit_done;
  assign msg_ready = fifo_count != CW'(FIFO_DEPTH);
  assign push = msg_valid && msg_ready;
  assign pop = (state == IDLE) && (fifo_count != '0);
  assign bit_done = baud_cnt == BW'(BIT_CYCLES - 1);
  assign busy = (state != IDLE) || (fifo_count != '0);
  // status bit 7 is forced high so any status field goes out as a valid status byte
  assign head = mem[rd_ptr] | 22'h20_0000;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {status, data1, data2};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  // the byte on the line always sits in shreg[7:0]; shifting out a byte exposes the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shreg    <= {1'b0, head[6:0], 1'b0, head[13:7], head[21:14]};
          byte_idx <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: if (bit_done) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= shreg[0];
          state    <= DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        DATA: if (bit_done) begin
          baud_cnt <= '0;
          shreg    <= shreg >> 1;
          bit_idx  <= bit_idx + 1'b1;
          tx       <= (bit_idx == 3'd7) ? 1'b1 : shreg[1];
          state    <= (bit_idx == 3'd7) ? STOP : DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        STOP: if (bit_done) begin
          baud_cnt <= '0;
          byte_idx <= (byte_idx != 2'd2) ? byte_idx + 1'b1 : byte_idx;
          tx       <= (byte_idx == 2'd2);
          state    <= (byte_idx != 2'd2) ? START : IDLE;
        end else baud_cnt <= baud_cnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: randomized bench comparing midi_msg_tx against a message-level timing model and a line decoder.
module tb_midi_msg_tx;
  localparam int FD = 4;
  localparam int BC = 10;
  localparam int MSG = 30 * BC;
  logic clk = 0, rst_n = 0, msg_valid = 0;
  logic [7:0] status = 0;
  logic [6:0] data1 = 0, data2 = 0;
  logic msg_ready, tx, busy;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_bad = 0;
  midi_msg_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .status(status), .data1(data1), .data2(data2),
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // message-level model: queue of pending messages plus cycles left on the line
  logic [21:0] q[$];
  logic [7:0] exp_q[$], rx_q[$];
  logic [7:0] cur [3];
  int rem = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      rem = 0;
    end else begin : model
      bit push, pop;
      logic [21:0] m;
      push = msg_valid && (q.size() != FD);
      pop = (rem == 0) && (q.size() != 0);
      if (pop) begin
        m = q.pop_front();
        cur[0] = m[21:14] | 8'h80;
        cur[1] = {1'b0, m[13:7]};
        cur[2] = {1'b0, m[6:0]};
        for (int i = 0; i < 3; i++) exp_q.push_back(cur[i]);
        rem = MSG;
      end else if (rem > 0) rem--;
      if (push) q.push_back({status, data1, data2});
    end
  function automatic logic model_tx();
    int e, pos, b;
    if (rem == 0) return 1'b1;
    e = MSG - rem;
    pos = e / BC;
    b = pos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[pos / 10][b - 1];
  endfunction
  always @(negedge clk) begin
    check("tx", tx, model_tx());
    check("busy", busy, (rem != 0) || (q.size() != 0));
    check("count", fifo_count, q.size());
    check("ready", msg_ready, q.size() != FD);
  end
  // independent line decoder sampling mid-bit
  int dc = 0;
  bit inf = 0;
  logic [7:0] sh;
  always @(negedge clk)
    if (!rst_n) inf = 0;
    else if (!inf) begin
      if (tx === 1'b0) begin
        inf = 1;
        dc = 0;
      end
    end else begin
      dc++;
      if (dc >= 15 && dc <= 85 && (dc - 15) % 10 == 0) sh[(dc - 15) / 10] = tx;
      if (dc == 95) begin
        rx_q.push_back(sh);
        inf = 0;
      end
    end
  task automatic send(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
    status = s;
    data1 = a;
    data2 = b;
    msg_valid = 1;
    for (int i = 0; i < 1000; i++) begin
      if (msg_ready) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 0, 1);
    msg_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rem == 0 && q.size() == 0) return;
    end
    check("idle_timeout", 0, 1);
  endtask
  task automatic compare_rx();
    check("rx_len", rx_q.size(), exp_q.size());
    while (rx_q.size() != 0 && exp_q.size() != 0) check("rx_byte", rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask
  initial begin
    msg_valid = 1;
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", msg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    msg_valid = 0;
    #2 rst_n = 1;
    @(negedge clk);
    send(8'h90, 7'd60, 7'd100);
    msg_valid = 0;
    check("note_tx_hold", tx, 1);
    @(negedge clk);
    check("note_tx_fall", tx, 0);
    wait_idle();
    check("note_b0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h90);
    check("note_b1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'h3C);
    check("note_b2", rx_q.size() > 2 ? rx_q[2] : 8'hxx, 8'h64);
    compare_rx();
    send(8'h10, 7'h7F, 7'h00);
    msg_valid = 0;
    wait_idle();
    check("mask_b0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h90);
    check("mask_b1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'h7F);
    check("mask_b2", rx_q.size() > 2 ? rx_q[2] : 8'hxx, 8'h00);
    compare_rx();
    send(8'h80, 7'd1, 7'd2);
    for (int i = 0; i < 5; i++) begin
      send($urandom_range(255), $urandom_range(127), $urandom_range(127));
      if (i == 3) check("fill_full", fifo_count, 4);
    end
    msg_valid = 0;
    wait_idle();
    compare_rx();
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 7'(i), 7'(i + 7));
    msg_valid = 0;
    for (int i = 0; i < 400 && !(rem == 0 && q.size() == 2); i++) @(negedge clk);
    check("pp_setup", q.size(), 2);
    send(8'hB5, 7'h55, 7'h2A);
    msg_valid = 0;
    check("pp_count", fifo_count, 2);
    wait_idle();
    compare_rx();
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(255), $urandom_range(127), $urandom_range(127));
      if ($urandom_range(1) == 1) begin
        msg_valid = 0;
        repeat ($urandom_range(400)) @(negedge clk);
      end
    end
    msg_valid = 0;
    wait_idle();
    compare_rx();
    send(8'h91, 7'h12, 7'h34);
    send(8'h92, 7'h56, 7'h78);
    send(8'h93, 7'h1A, 7'h2B);
    msg_valid = 0;
    for (int i = 0; i < 400 && rem != MSG - 145; i++) @(negedge clk);
    check("mid_setup", rem, MSG - 145);
    #2 rst_n = 0;
    #1;
    check("mid_tx", tx, 1);
    check("mid_count", fifo_count, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", msg_ready, 1);
    repeat (3) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    #2 rst_n = 1;
    @(negedge clk);
    send(8'h95, 7'h40, 7'h3F);
    msg_valid = 0;
    wait_idle();
    check("post_b0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h95);
    compare_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
